// File: rtl/seq_detector_param_if.sv
// Stream, configuration and status signals of the serial pattern detector.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               din;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               dout;
    logic [CNT_W-1:0]   match_count;
    logic               cnt_ovf;

    modport master (
        output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  dout, match_count, cnt_ovf
    );

    modport slave (
        input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output dout, match_count, cnt_ovf
    );
endinterface

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern/length, optional
// overlapping matches and a saturating match counter with sticky overflow.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    seq_detector_param_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               dout_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic               shift_en;
    logic               match;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_q));
    end

    // Match is evaluated on the post-shift view so dout has exactly one cycle latency.
    assign shift_en = bus.din_valid && !bus.cfg_load;
    assign hist_nxt = {hist_q[MAX_LEN-2:0], bus.din};
    assign fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    assign match    = shift_en && (len_q != '0) && (fill_inc >= len_q)
                   && (((hist_nxt ^ pat_q) & mask) == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
        end else if (bus.cfg_load) begin
            pat_q  <= bus.cfg_pattern;
            len_q  <= (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
            ovl_q  <= bus.cfg_overlap;
            hist_q <= '0;
            fill_q <= '0;
        end else if (bus.din_valid) begin
            hist_q <= hist_nxt;
            fill_q <= (match && !ovl_q) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            dout_q <= match;
            if (bus.cnt_clr) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (match) begin
                if (&cnt_q) ovf_q <= 1'b1;
                else        cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.dout        = dout_q;
    assign bus.match_count = cnt_q;
    assign bus.cnt_ovf     = ovf_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: a default instance plus a CNT_W=2 instance share one stimulus stream.
module tb_seq_detector_param;
    logic       clk = 1'b0;
    logic       resetn;
    logic       din, din_valid, cfg_load, cfg_overlap, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    int         errors = 0;
    int         checks = 0;
    int         s_cnt;
    logic       s_ovf;

    always #5 clk = ~clk;

    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) bus_a ();
    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) bus_s ();

    assign bus_a.din = din;          assign bus_s.din = din;
    assign bus_a.din_valid = din_valid; assign bus_s.din_valid = din_valid;
    assign bus_a.cfg_load = cfg_load;   assign bus_s.cfg_load = cfg_load;
    assign bus_a.cfg_pattern = cfg_pattern; assign bus_s.cfg_pattern = cfg_pattern;
    assign bus_a.cfg_len = cfg_len;     assign bus_s.cfg_len = cfg_len;
    assign bus_a.cfg_overlap = cfg_overlap; assign bus_s.cfg_overlap = cfg_overlap;
    assign bus_a.cnt_clr = cnt_clr;     assign bus_s.cnt_clr = cnt_clr;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut   (.clk(clk), .resetn(resetn), .bus(bus_a));
    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_s (.clk(clk), .resetn(resetn), .bus(bus_s));

    // One clock with the given inputs; returns at the following negedge.
    task automatic step(input logic v, input logic d, input logic clr, input logic ld);
        din_valid = v; din = d; cnt_clr = clr; cfg_load = ld;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0; cnt_clr = 1'b0; cfg_load = 1'b0;
    endtask

    // Load with din_valid=1 and din=1 so any leak of the load-cycle bit shows up.
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        if (bus_a.match_count !== 8'd0) begin
            errors++; $display("FAIL load_clr: got count %0d want 0", bus_a.match_count);
        end
        checks++;
    endtask

    task automatic test_reset();
        resetn = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        #3;
        if ({bus_a.dout, bus_a.match_count, bus_a.cnt_ovf, bus_s.match_count, bus_s.cnt_ovf} !== 13'd0) begin
            errors++; $display("FAIL reset_state: got %b want 0",
                {bus_a.dout, bus_a.match_count, bus_a.cnt_ovf, bus_s.match_count, bus_s.cnt_ovf});
        end
        checks++;
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overlap();
        logic [5:0] bits = 6'b101010;
        logic [5:0] exp  = 6'b000101;
        load(8'b1010, 4'd4, 1'b1);
        for (int i = 5; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            if (bus_a.dout !== exp[i]) begin
                errors++; $display("FAIL ovl_dout bit%0d: got %b want %b", 6 - i, bus_a.dout, exp[i]);
            end
            checks++;
        end
        if (bus_a.match_count !== 8'd2) begin
            errors++; $display("FAIL ovl_count: got %0d want 2", bus_a.match_count);
        end
        checks++;
    endtask

    task automatic test_non_overlap();
        logic [5:0] bits = 6'b101010;
        logic [5:0] exp  = 6'b000100;
        load(8'b1010, 4'd4, 1'b0);
        for (int i = 5; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            if (bus_a.dout !== exp[i]) begin
                errors++; $display("FAIL novl_dout bit%0d: got %b want %b", 6 - i, bus_a.dout, exp[i]);
            end
            checks++;
        end
        if (bus_a.match_count !== 8'd1) begin
            errors++; $display("FAIL novl_count: got %0d want 1", bus_a.match_count);
        end
        checks++;
    endtask

    task automatic test_stall();
        logic [3:0] bits = 4'b1010;
        load(8'b1010, 4'd4, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            if (bus_a.dout !== (i == 0)) begin
                errors++; $display("FAIL stall_dout bit%0d: got %b want %b", 4 - i, bus_a.dout, (i == 0));
            end
            checks++;
            for (int g = 0; g < 3; g++) begin
                step(1'b0, ~bits[i], 1'b0, 1'b0);
                if (bus_a.dout !== 1'b0) begin
                    errors++; $display("FAIL stall_gap bit%0d gap%0d: got %b want 0", 4 - i, g, bus_a.dout);
                end
                checks++;
            end
        end
        if (bus_a.match_count !== 8'd1) begin
            errors++; $display("FAIL stall_count: got %0d want 1", bus_a.match_count);
        end
        checks++;
    endtask

    task automatic test_saturation();
        logic exp;
        load(8'b1010, 4'd4, 1'b1);
        s_cnt = 0; s_ovf = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            exp = (n >= 4) && (n % 2 == 0);
            step(1'b1, n[0], 1'b0, 1'b0);
            if (exp) begin
                if (s_cnt == 3) s_ovf = 1'b1;
                else            s_cnt++;
            end
            if (bus_s.dout !== exp || bus_s.match_count !== 2'(s_cnt) || bus_s.cnt_ovf !== s_ovf) begin
                errors++; $display("FAIL sat bit%0d: got dout=%b cnt=%0d ovf=%b want dout=%b cnt=%0d ovf=%b",
                    n, bus_s.dout, bus_s.match_count, bus_s.cnt_ovf, exp, s_cnt, s_ovf);
            end
            checks++;
        end
        if (bus_a.match_count !== 8'd5 || bus_s.match_count !== 2'd3 || bus_s.cnt_ovf !== 1'b1) begin
            errors++; $display("FAIL sat_final: got a=%0d s=%0d ovf=%b want 5 3 1",
                bus_a.match_count, bus_s.match_count, bus_s.cnt_ovf);
        end
        checks++;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        if (bus_s.dout !== 1'b1 || bus_s.match_count !== 2'd0 || bus_s.cnt_ovf !== 1'b0 || bus_a.match_count !== 8'd0) begin
            errors++; $display("FAIL clr_vs_match: got dout=%b cnt=%0d ovf=%b a=%0d want 1 0 0 0",
                bus_s.dout, bus_s.match_count, bus_s.cnt_ovf, bus_a.match_count);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [6:0] pre = 7'b1010101;
        logic [4:0] post = 5'b01010;
        load(8'b1010, 4'd4, 1'b0);
        for (int i = 6; i >= 0; i--) step(1'b1, pre[i], 1'b0, 1'b0);
        if (bus_a.match_count !== 8'd1) begin
            errors++; $display("FAIL mid_pre_count: got %0d want 1", bus_a.match_count);
        end
        checks++;
        #2 resetn = 1'b0;
        #1;
        if (bus_a.dout !== 1'b0 || bus_a.match_count !== 8'd0 || bus_a.cnt_ovf !== 1'b0) begin
            errors++; $display("FAIL mid_async_rst: got dout=%b cnt=%0d ovf=%b want 0 0 0",
                bus_a.dout, bus_a.match_count, bus_a.cnt_ovf);
        end
        checks++;
        @(negedge clk);
        resetn = 1'b1;
        // Configuration is back to len=0 after reset, so nothing may match without a reload.
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, post[i], 1'b0, 1'b0);
            if (bus_a.dout !== 1'b0) begin
                errors++; $display("FAIL mid_noload bit%0d: got %b want 0", 4 - i, bus_a.dout);
            end
            checks++;
        end
        load(8'b1010, 4'd4, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, post[i], 1'b0, 1'b0);
            if (bus_a.dout !== (i == 0)) begin
                errors++; $display("FAIL mid_reload bit%0d: got %b want %b", 5 - i, bus_a.dout, (i == 0));
            end
            checks++;
        end
    endtask

    task automatic test_len_clamp();
        load(8'hFF, 4'd9, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (bus_a.dout !== (n == 8)) begin
                errors++; $display("FAIL clamp bit%0d: got %b want %b", n, bus_a.dout, (n == 8));
            end
            checks++;
        end
        load(8'h00, 4'd0, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            step(1'b1, n > 9, 1'b0, 1'b0);
            if (bus_a.dout !== 1'b0) begin
                errors++; $display("FAIL len0 bit%0d: got %b want 0", n, bus_a.dout);
            end
            checks++;
        end
        if (bus_a.match_count !== 8'd0) begin
            errors++; $display("FAIL len0_count: got %0d want 0", bus_a.match_count);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_stall();
        test_saturation();
        test_reset_mid();
        test_len_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
